param_sa_cache: RTL

PARAM_SA_CACHE -- requirements
Module: param_sa_cache

---
 rtl/param_sa_cache.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/param_sa_cache.sv
// param_sa_cache
//   Set-associative, write-back, write-allocate cache with true-LRU
//   replacement and a single outstanding line transfer to memory.
//
//   Clock / reset : CLK (rising edge), RST_N (asynchronous, active low)
//   CPU side      : cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be -> cpu_rdata,
//                   cpu_ready (combinational, asserted on the hit cycle)
//   Memory side   : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
//                   (whole-line transfers, word 0 in the LSBs)
//   Statistics    : hit_cnt, miss_cnt (wrapping 32-bit)
//
//   A miss moves IDLE -> WRITEBACK (dirty victim) or IDLE -> FILL. After the
//   fill returns to IDLE the still-pending request hits and completes.
module param_sa_cache #(
    parameter int NUM_SETS    = 4,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_be,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [32*BLOCK_WORDS-1:0] mem_wdata,
    input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
    input  logic                      mem_ack,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
);
    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int LSB_W  = 2 + OFF_W;
    localparam int TAG_W  = 32 - LSB_W - IDX_W;
    localparam int LINE_W = 32 * BLOCK_WORDS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t              state;
    logic [LINE_W-1:0]   line_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

    // Miss context captured on the IDLE exit so the transfer can finish
    // even if the CPU withdraws its request.
    logic [WAY_W-1:0]    vict_q;
    logic [IDX_W-1:0]    fill_idx_q;
    logic [TAG_W-1:0]    fill_tag_q;

    logic [OFF_W-1:0]    woff;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic                found_inv;
    logic [WAY_W-1:0]    vict_way;
    logic                hit;
    logic                miss;
    logic                xfer_done;
    logic [31:0]         hit_word;
    logic                unused_addr_lsb;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    assign woff = cpu_addr[2 +: OFF_W];
    assign idx  = cpu_addr[LSB_W +: IDX_W];
    assign tag  = cpu_addr[31 -: TAG_W];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // Tag compare across the indexed set; at most one way can match.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the oldest way. Ages in a set
    // are always a permutation, so the oldest way holds NUM_WAYS-1.
    always_comb begin
        found_inv = 1'b0;
        vict_way  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_q[idx][w] && !found_inv) begin
                found_inv = 1'b1;
                vict_way  = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) vict_way = WAY_W'(w);
            end
        end
    end

    assign hit       = cpu_req && (state == IDLE) && hit_any;
    assign miss      = cpu_req && (state == IDLE) && !hit_any;
    assign xfer_done = mem_req && mem_ack;
    assign hit_word  = line_q[idx][hit_way][{woff, 5'b0} +: 32];
    assign cpu_ready = hit;
    assign cpu_rdata = hit ? hit_word : 32'd0;

    // Control: FSM, memory request registers, valid/dirty/LRU, counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            vict_q     <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == hit_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < age_q[idx][hit_way])
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
                if (cpu_we) dirty_q[idx][hit_way] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_cnt   <= miss_cnt + 32'd1;
                        vict_q     <= vict_way;
                        fill_idx_q <= idx;
                        fill_tag_q <= tag;
                        mem_req    <= 1'b1;
                        if (valid_q[idx][vict_way] && dirty_q[idx][vict_way]) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[idx][vict_way], idx, {LSB_W{1'b0}}};
                            mem_wdata <= line_q[idx][vict_way];
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {cpu_addr[31:LSB_W], {LSB_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (xfer_done) begin
                        state     <= FILL;
                        mem_we    <= 1'b0;
                        mem_addr  <= {fill_tag_q, fill_idx_q, {LSB_W{1'b0}}};
                        mem_wdata <= '0;
                    end
                end
                FILL: begin
                    if (xfer_done) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        valid_q[fill_idx_q][vict_q] <= 1'b1;
                        dirty_q[fill_idx_q][vict_q] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and tag storage. An aborted fill never reaches this write because
    // reset forces the FSM out of FILL and drops mem_req.
    always_ff @(posedge CLK) begin
        if (hit && cpu_we)
            line_q[idx][hit_way][{woff, 5'b0} +: 32] <= merge_be(hit_word, cpu_wdata, cpu_be);
        if ((state == FILL) && xfer_done) begin
            line_q[fill_idx_q][vict_q] <= mem_rdata;
            tag_q[fill_idx_q][vict_q]  <= fill_tag_q;
        end
    end

endmodule
